score_seg_bcd_mux: RTL

Parametrised BCD score counter with a multiplexed seven-segment display driver for the game top level. It counts rising edges on two scoring inputs (cube eaten, reward bonus) into a DIGITS-wide BCD score, saturating at all nines. It scans the score out to a common-anode, active-low display one digit at a time. It supersedes the fixed 4-digit scorer: digit count and scan rate are generic, simultaneous score events are both counted, overflow is reported, and the display blanks cleanly on reset.

---
 rtl/score_seg_bcd_mux_if.sv | 23 ++
 rtl/score_seg_bcd_mux.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/score_seg_bcd_mux_if.sv
// Bundle of score/display signals between the game top level and score_seg_bcd_mux.
// The game logic drives the master side; the scorer is the slave.
interface score_seg_bcd_mux_if #(
  parameter int DIGITS = 4
);
  logic                  clear;
  logic                  add_cube;
  logic                  reward_grade;
  logic [4*DIGITS-1:0]   score;
  logic                  overflow;
  logic [7:0]            seg_out;
  logic [DIGITS-1:0]     sel;

  modport master (
    output clear, add_cube, reward_grade,
    input  score, overflow, seg_out, sel
  );

  modport slave (
    input  clear, add_cube, reward_grade,
    output score, overflow, seg_out, sel
  );
endinterface

// File: rtl/score_seg_bcd_mux.sv
// Saturating BCD score counter with a multiplexed active-low 7-segment driver.
// Optional macro SEG_LZ_BLANK_EN enables leading-zero blanking of digits 1..DIGITS-1.

// One decimal digit of the ripple adder; carry-in reaches 2 only on digit 0.
module score_seg_bcd_digit (
  input  logic [3:0] i_d,
  input  logic [1:0] i_cin,
  output logic [3:0] o_q,
  output logic       o_cout
);
  logic [4:0] w_sum;

  assign w_sum  = {1'b0, i_d} + {3'b000, i_cin};
  assign o_cout = (w_sum > 5'd9);
  assign o_q    = o_cout ? 4'(w_sum - 5'd10) : w_sum[3:0];
endmodule

module score_seg_bcd_mux #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  score_seg_bcd_mux_if.slave   bus
);
  localparam int RC_W = $clog2(REFRESH_CYCLES);
  localparam int DX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                   w_restart;
  logic                   r_prev_cube;
  logic                   r_prev_reward;
  logic [1:0]             w_inc;

  logic [DIGITS-1:0][3:0] r_score;
  logic [DIGITS-1:0][3:0] w_sum;
  logic [DIGITS-1:0][1:0] w_cin;
  logic [DIGITS-1:0]      w_cout;
  logic                   r_ovf;

  logic [RC_W-1:0]        r_rcnt;
  logic [DX_W-1:0]        r_didx;
  logic [3:0]             w_cur;
  logic [7:0]             w_seg_nxt;
  logic [DIGITS-1:0]      w_sel_nxt;
  logic [7:0]             r_seg;
  logic [DIGITS-1:0]      r_sel;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  assign w_restart = rst | bus.clear;

  // Both rising edges in one cycle are summed so neither event is lost.
  assign w_inc = {1'b0, bus.add_cube & ~r_prev_cube}
               + {1'b0, bus.reward_grade & ~r_prev_reward};

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      if (g == 0) begin : g_lsd
        assign w_cin[g] = w_inc;
      end else begin : g_hi
        assign w_cin[g] = {1'b0, w_cout[g-1]};
      end
      score_seg_bcd_digit u_dig (
        .i_d    (r_score[g]),
        .i_cin  (w_cin[g]),
        .o_q    (w_sum[g]),
        .o_cout (w_cout[g])
      );
    end
  endgenerate

  // Edge detectors keep sampling through reset/clear so a held level never re-fires.
  always_ff @(posedge clk) begin
    r_prev_cube   <= bus.add_cube;
    r_prev_reward <= bus.reward_grade;
  end

  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_score <= '0;
      r_ovf   <= 1'b0;
    end else if (w_cout[DIGITS-1]) begin
      r_score <= {DIGITS{4'd9}};
      r_ovf   <= 1'b1;
    end else begin
      r_score <= w_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_rcnt <= '0;
      r_didx <= '0;
    end else if (r_rcnt == RC_W'(REFRESH_CYCLES - 1)) begin
      r_rcnt <= '0;
      r_didx <= (r_didx == DX_W'(DIGITS - 1)) ? '0 : r_didx + 1'b1;
    end else begin
      r_rcnt <= r_rcnt + 1'b1;
    end
  end

  assign w_cur = r_score[r_didx];

`ifdef SEG_LZ_BLANK_EN
  // w_hi_zero[i]: digits i..DIGITS-1 are all zero.
  logic [DIGITS-1:0] w_hi_zero;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_lz
      if (g == DIGITS - 1) begin : g_top
        assign w_hi_zero[g] = (r_score[g] == 4'd0);
      end else begin : g_mid
        assign w_hi_zero[g] = (r_score[g] == 4'd0) & w_hi_zero[g+1];
      end
    end
  endgenerate
`endif

  always_comb begin
    w_sel_nxt = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_didx == DX_W'(i)) w_sel_nxt[DIGITS-1-i] = 1'b0;
    end
    w_seg_nxt = seg_decode(w_cur);
`ifdef SEG_LZ_BLANK_EN
    if ((r_didx != '0) && w_hi_zero[r_didx]) w_seg_nxt = 8'hFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_seg <= 8'hFF;
      r_sel <= '1;
    end else begin
      r_seg <= w_seg_nxt;
      r_sel <= w_sel_nxt;
    end
  end

  assign bus.score    = r_score;
  assign bus.overflow = r_ovf;
  assign bus.seg_out  = r_seg;
  assign bus.sel      = r_sel;
endmodule
